// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: prioritised stall/flush, E-stage operand
// forwarding, long-latency register scoreboard and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int NREG    = 32,
  parameter int REG_AW  = 5,
  parameter int MAX_OUT = 4,
  parameter int CNT_AW  = 3,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              CpuRst,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadD,
  input  logic [1:0]        RegReadE,
  input  logic              MemToRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LongIssueE,
  input  logic              LongDoneW,
  input  logic [REG_AW-1:0] LongRdW,
  output logic              StallF,
  output logic              FlushF,
  output logic              StallD,
  output logic              FlushD,
  output logic              StallE,
  output logic              FlushE,
  output logic              StallM,
  output logic              FlushM,
  output logic              StallW,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic              SbBusy,
  output logic              SbError,
  output logic [PERF_W-1:0] StallCnt
);

  logic [NREG-1:0]   sb;
  logic [NREG-1:0]   sb_set;
  logic [NREG-1:0]   sb_clr;
  logic [NREG-1:0]   sb_next;
  logic [CNT_AW-1:0] cnt;
  logic              sb_error;
  logic [PERF_W-1:0] stall_cnt;

  logic load_use, sb_raw, waw_full, issue;
  logic s_f, s_d, s_e, s_m, f_d, f_e, f_m, f_w;
  logic [1:0] fwd1, fwd2;

  always_comb begin
    load_use = MemToRegE && (RdE != '0) &&
               ((RegReadD[1] && (RdE == Rs1D)) || (RegReadD[0] && (RdE == Rs2D)));
    sb_raw   = (RegReadD[1] && sb[Rs1D]) || (RegReadD[0] && sb[Rs2D]);
    waw_full = LongIssueE && (sb[RdE] || (cnt == CNT_AW'(MAX_OUT)));
  end

  // Base priority chain, then the I-cache overlay.
  always_comb begin
    s_f = 1'b0; s_d = 1'b0; s_e = 1'b0; s_m = 1'b0;
    f_d = 1'b0; f_e = 1'b0; f_m = 1'b0; f_w = 1'b0;
    if (DCacheMiss) begin
      s_f = 1'b1; s_d = 1'b1; s_e = 1'b1; s_m = 1'b1; f_w = 1'b1;
    end else if (BranchE || JalrE) begin
      f_d = 1'b1; f_e = 1'b1;
    end else if (waw_full) begin
      s_f = 1'b1; s_d = 1'b1; s_e = 1'b1; f_m = 1'b1;
    end else if (load_use || sb_raw) begin
      s_f = 1'b1; s_d = 1'b1; f_e = 1'b1;
    end else if (JalD) begin
      f_d = 1'b1;
    end
    if (ICacheMiss && !DCacheMiss) begin
      s_f = 1'b1;
      if (!s_d) f_d = 1'b1;
    end
  end

  always_comb begin
    fwd1 = 2'b00;
    if (RegReadE[1] && RegWriteM && (RdM != '0) && (RdM == Rs1E))      fwd1 = 2'b10;
    else if (RegReadE[1] && RegWriteW && (RdW != '0) && (RdW == Rs1E)) fwd1 = 2'b01;
    fwd2 = 2'b00;
    if (RegReadE[0] && RegWriteM && (RdM != '0) && (RdM == Rs2E))      fwd2 = 2'b10;
    else if (RegReadE[0] && RegWriteW && (RdW != '0) && (RdW == Rs2E)) fwd2 = 2'b01;
  end

  // Reset forces every stage register to flush regardless of hazards.
  always_comb begin
    StallF    = CpuRst ? 1'b0 : s_f;
    StallD    = CpuRst ? 1'b0 : s_d;
    StallE    = CpuRst ? 1'b0 : s_e;
    StallM    = CpuRst ? 1'b0 : s_m;
    StallW    = 1'b0;
    FlushF    = CpuRst;
    FlushD    = CpuRst ? 1'b1 : f_d;
    FlushE    = CpuRst ? 1'b1 : f_e;
    FlushM    = CpuRst ? 1'b1 : f_m;
    FlushW    = CpuRst ? 1'b1 : f_w;
    Forward1E = CpuRst ? 2'b00 : fwd1;
    Forward2E = CpuRst ? 2'b00 : fwd2;
  end

  // An issue with RdE==0 is counted but never marks the scoreboard.
  always_comb begin
    issue   = LongIssueE && !s_e && !f_e;
    sb_set  = (issue && (RdE != '0)) ? (NREG'(1) << RdE) : '0;
    sb_clr  = (LongDoneW && (LongRdW != '0)) ? (NREG'(1) << LongRdW) : '0;
    sb_next = (sb & ~sb_clr) | sb_set;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      sb        <= '0;
      cnt       <= '0;
      sb_error  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      sb <= sb_next;
      if (issue && !LongDoneW)
        cnt <= cnt + CNT_AW'(1);
      else if (LongDoneW && !issue && (cnt != '0))
        cnt <= cnt - CNT_AW'(1);
      if (LongDoneW && (cnt == '0))
        sb_error <= 1'b1;
      if (s_f && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign SbBusy   = |sb;
  assign SbError  = sb_error;
  assign StallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios plus randomized traffic, all checked
// against a rule-level reference model of the hazard unit.
module tb_hazard_unit_mc;
  localparam int NREG = 32, REG_AW = 5, MAX_OUT = 4, CNT_AW = 3, PERF_W = 4;
  localparam int CNT_MAX = (1 << PERF_W) - 1;

  logic clk, CpuRst;
  logic ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
  logic [1:0] RegReadD, RegReadE;
  logic MemToRegE, RegWriteM, RegWriteW, LongIssueE, LongDoneW;
  logic StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic [1:0] Forward1E, Forward2E;
  logic SbBusy, SbError;
  logic [PERF_W-1:0] StallCnt;

  hazard_unit_mc #(.NREG(NREG), .REG_AW(REG_AW), .MAX_OUT(MAX_OUT), .CNT_AW(CNT_AW),
                   .PERF_W(PERF_W)) dut (
    .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadD(RegReadD), .RegReadE(RegReadE), .MemToRegE(MemToRegE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LongIssueE(LongIssueE),
    .LongDoneW(LongDoneW), .LongRdW(LongRdW),
    .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
    .StallW(StallW), .FlushW(FlushW), .Forward1E(Forward1E), .Forward2E(Forward2E),
    .SbBusy(SbBusy), .SbError(SbError), .StallCnt(StallCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit busy[NREG];
  int outstanding;
  bit err;
  int stalls;
  bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw;
  int e_f1, e_f2;
  logic [13:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_ref(input bit used, input int rs);
    if (used && RegWriteM && RdM != 0 && int'(RdM) == rs) return 2;
    if (used && RegWriteW && RdW != 0 && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  function automatic bit any_busy();
    for (int i = 0; i < NREG; i++) if (busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) busy[i] = 1'b0;
    outstanding = 0; err = 1'b0; stalls = 0;
  endtask

  task automatic model_eval();
    bit lu, raw;
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw} = '0;
    lu  = MemToRegE && RdE != 0 &&
          ((RegReadD[1] && RdE == Rs1D) || (RegReadD[0] && RdE == Rs2D));
    raw = lu || (RegReadD[1] && busy[Rs1D]) || (RegReadD[0] && busy[Rs2D]);
    if (DCacheMiss) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
    end else if (BranchE || JalrE) begin
      e_fd = 1; e_fe = 1;
    end else if (LongIssueE && (busy[RdE] || outstanding == MAX_OUT)) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
    end else if (raw) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end else if (JalD) begin
      e_fd = 1;
    end
    if (ICacheMiss && !DCacheMiss) begin
      e_sf = 1;
      if (!e_sd) e_fd = 1;
    end
    e_f1 = fwd_ref(RegReadE[1], int'(Rs1E));
    e_f2 = fwd_ref(RegReadE[0], int'(Rs2E));
  endtask

  task automatic model_update();
    bit iss;
    iss = LongIssueE && !e_se && !e_fe;
    if (LongDoneW && LongRdW != 0) busy[LongRdW] = 1'b0;
    if (iss && RdE != 0) busy[RdE] = 1'b1;
    if (LongDoneW && outstanding == 0) err = 1'b1;
    if (iss && !LongDoneW) outstanding++;
    else if (LongDoneW && !iss && outstanding > 0) outstanding--;
    if (e_sf && stalls < CNT_MAX) stalls++;
  endtask

  // driver tasks
  task automatic idle();
    {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD} = '0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW} = '0;
    RegReadD = 2'b00; RegReadE = 2'b00;
    {MemToRegE, RegWriteM, RegWriteW, LongIssueE, LongDoneW} = '0;
  endtask

  // Called at posedge+1: compare at the falling edge, then advance the model at posedge.
  task automatic settle_check();
    #4;
    model_eval();
    exp_q.push_back({e_sf, 1'b0, e_sd, e_fd, e_se, e_fe, e_sm, e_fm, 1'b0, e_fw,
                     2'(e_f1), 2'(e_f2)});
    check("ctrl", {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM,
                   StallW, FlushW, Forward1E, Forward2E}, exp_q.pop_front());
    check("sb_busy", SbBusy, any_busy());
    check("sb_error", SbError, err);
    check("stall_cnt", StallCnt, stalls);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic reset_pulse();
    #2 CpuRst = 1'b1;
    #1;
    check("rst_ctrl", {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM,
                       StallW, FlushW, Forward1E, Forward2E}, 14'b01010101010000);
    check("rst_sb_busy", SbBusy, 0);
    check("rst_sb_error", SbError, 0);
    check("rst_stall_cnt", StallCnt, 0);
    @(negedge clk);
    CpuRst = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    int list[$];
    ICacheMiss = ($urandom_range(0, 7) == 0);
    DCacheMiss = ($urandom_range(0, 15) == 0);
    BranchE    = ($urandom_range(0, 9) == 0);
    JalrE      = ($urandom_range(0, 19) == 0);
    JalD       = ($urandom_range(0, 9) == 0);
    Rs1D = REG_AW'($urandom_range(0, 7)); Rs2D = REG_AW'($urandom_range(0, 7));
    Rs1E = REG_AW'($urandom_range(0, 7)); Rs2E = REG_AW'($urandom_range(0, 7));
    RdE  = REG_AW'($urandom_range(0, 7)); RdM  = REG_AW'($urandom_range(0, 7));
    RdW  = REG_AW'($urandom_range(0, 7));
    RegReadD   = 2'($urandom_range(0, 3));
    RegReadE   = 2'($urandom_range(0, 3));
    MemToRegE  = ($urandom_range(0, 3) == 0);
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    LongIssueE = ($urandom_range(0, 3) == 0);
    LongDoneW  = (outstanding > 0) && ($urandom_range(0, 3) == 0);
    LongRdW    = '0;
    if (LongDoneW) begin
      RegWriteW = 1'b1;
      for (int i = 1; i < NREG; i++) if (busy[i]) list.push_back(i);
      if (list.size() > 0) LongRdW = REG_AW'(list[$urandom_range(0, list.size() - 1)]);
    end
  endtask

  initial begin
    CpuRst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    reset_pulse();

    // state built up mid-operation, then cleared asynchronously
    LongIssueE = 1; RdE = 5; step();
    RdE = 6; step();
    idle(); ICacheMiss = 1;
    repeat (7) step();
    check("pre_rst_stall_cnt", StallCnt, 7);
    check("pre_rst_busy", SbBusy, 1);
    idle();
    reset_pulse();

    // load-use, then W forwarding of the loaded value
    MemToRegE = 1; RdE = 3; Rs1D = 3; RegReadD = 2'b10;
    settle_check();
    check("lu_stallf", StallF, 1); check("lu_flushe", FlushE, 1);
    advance();
    idle(); Rs1E = 3; RdW = 3; RegWriteW = 1; RegReadE = 2'b10;
    settle_check();
    check("lu_fwd_w", Forward1E, 2'b01); check("lu_released", StallD, 0);
    advance();
    idle(); MemToRegE = 1; RdE = 0; Rs1D = 0; RegReadD = 2'b10;
    settle_check(); check("lu_x0_nostall", StallF, 0); advance();

    // scoreboard RAW held through the done cycle
    idle(); LongIssueE = 1; RdE = 7;
    settle_check(); check("div_accept", StallE, 0); advance();
    idle(); Rs2D = 7; RegReadD = 2'b01;
    repeat (3) begin settle_check(); check("sb_raw_stall", StallD, 1); advance(); end
    LongDoneW = 1; LongRdW = 7; RegWriteW = 1;
    settle_check(); check("sb_raw_done_cycle", StallD, 1); advance();
    LongDoneW = 0; RegWriteW = 0;
    settle_check(); check("sb_raw_release", StallD, 0); check("sb7_clear", SbBusy, 0);
    advance();

    // full scoreboard, then WAW on a busy register
    for (int r = 1; r <= 4; r++) begin idle(); LongIssueE = 1; RdE = REG_AW'(r); step(); end
    idle(); LongIssueE = 1; RdE = 5;
    settle_check(); check("full_stalle", StallE, 1); check("full_flushm", FlushM, 1); advance();
    LongDoneW = 1; LongRdW = 1;
    settle_check(); check("full_done_cycle", StallE, 1); advance();
    LongDoneW = 0;
    settle_check(); check("fifth_accept", StallE, 0); advance();
    idle(); LongDoneW = 1; LongRdW = 5; step();
    idle(); LongIssueE = 1; RdE = 2;
    settle_check(); check("waw_stalle", StallE, 1); check("waw_flushm", FlushM, 1); advance();
    for (int r = 2; r <= 4; r++) begin idle(); LongDoneW = 1; LongRdW = REG_AW'(r); step(); end
    idle(); settle_check(); check("drained", SbBusy, 0); advance();

    // priority
    DCacheMiss = 1; BranchE = 1;
    settle_check();
    check("dmiss_flushd", FlushD, 0); check("dmiss_flushw", FlushW, 1); check("dmiss_stallm", StallM, 1);
    advance();
    idle(); ICacheMiss = 1; MemToRegE = 1; RdE = 3; Rs1D = 3; RegReadD = 2'b10;
    settle_check();
    check("imiss_raw_stalld", StallD, 1); check("imiss_raw_flushe", FlushE, 1);
    check("imiss_raw_flushd", FlushD, 0);
    advance();
    idle(); ICacheMiss = 1;
    settle_check(); check("imiss_stallf", StallF, 1); check("imiss_flushd", FlushD, 1); advance();

    // M over W forwarding
    idle(); RdM = 9; RdW = 9; Rs1E = 9; Rs2E = 9; RegWriteM = 1; RegWriteW = 1; RegReadE = 2'b11;
    settle_check(); check("fwd_m_over_w", Forward1E, 2'b10); advance();

    // saturation of the stall counter
    idle(); ICacheMiss = 1;
    repeat (20) step();
    check("stall_sat", StallCnt, CNT_MAX);

    // done with nothing outstanding
    idle(); LongDoneW = 1; step();
    idle(); step();
    check("sb_error_set", SbError, 1);
    repeat (3) step();
    check("sb_error_sticky", SbError, 1);
    reset_pulse();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Second-generation hazard unit for the 5-stage RISC-V pipeline (F, D, E, M, W), replacing the merged MW stage. It generates per-stage stall/flush, 2-bit E-stage forwarding selects (M over W) and a register scoreboard for variable-latency units (mul/div, non-blocking loads). It also keeps a saturating stall-cycle performance counter. It sits beside the datapath and drives every stage register's Stall/Flush pins.

Parameters:
NREG, 32, architectural register count (x0 hardwired zero)
REG_AW, 5, register index width, = clog2(NREG)
MAX_OUT, 4, max in-flight long-latency ops (1..2^CNT_AW-1)
CNT_AW, 3, outstanding-counter width
PERF_W, 32, stall-counter width

Ports:
clk  in  1  clock, rising edge
CpuRst  in  1  asynchronous active-high reset
ICacheMiss, DCacheMiss  in  1  cache miss, held high until refill completes
BranchE, JalrE, JalD  in  1  control-transfer taken
Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  register indices per stage
RegReadD, RegReadE  in  2  [1]=rs1 used, [0]=rs2 used
MemToRegE  in  1  load in E
RegWriteM, RegWriteW  in  1  stage writes Rd
LongIssueE  in  1  E holds long-latency op writing RdE
LongDoneW, LongRdW  in  1, REG_AW  long unit writes back LongRdW this cycle
StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1  stage controls
Forward1E, Forward2E  out  2  00 regfile, 01 from W, 10 from M
SbBusy  out  1  any scoreboard bit set
SbError  out  1  sticky: LongDoneW seen with zero outstanding
StallCnt  out  PERF_W  cycles with StallF=1

Behaviour:
- Reset (CpuRst high, async): scoreboard, outstanding count, SbError and StallCnt cleared immediately. While CpuRst is high, all Flush outputs = 1, all Stall outputs = 0, and Forward = 00.
- Stall/flush. Base priority, first match wins; unlisted outputs = 0:
  1. DCacheMiss: StallF/D/E/M=1, FlushW=1.
  2. BranchE|JalrE: FlushD=1, FlushE=1.
  3. WAW/full: LongIssueE & (sb[RdE] | count==MAX_OUT): StallF/D/E=1, FlushM=1.
  4. RAW: load-use (MemToRegE & RdE!=0 & ((RegReadD[1]&RdE==Rs1D)|(RegReadD[0]&RdE==Rs2D))), or scoreboard (RegReadD[1]&sb[Rs1D] | RegReadD[0]&sb[Rs2D]): StallF/D=1, FlushE=1.
  5. JalD: FlushD=1.
- ICacheMiss & !DCacheMiss overlays the base result: StallF=1; FlushD=1 only if StallD=0. FlushF is never asserted outside reset.
- Forwarding, per operand:
  - 10 if RegReadE bit & RegWriteM & RdM!=0 & RdM==RsE.
  - else 01 if RegReadE bit & RegWriteW & RdW!=0 & RdW==RsE.
  - else 00.
  - The long unit asserts RegWriteW on its writeback cycle.
- Scoreboard (NREG bits, bit 0 constant 0):
  - Issue accepted = LongIssueE & !StallE & !FlushE & RdE!=0. It sets sb[RdE] at the clock edge.
  - LongDoneW & LongRdW!=0 clears sb[LongRdW].
  - Same register set and cleared in one cycle: set wins.
  - Scoreboard RAW checks use registered sb only; there is no bypass of LongDoneW. A consumer stalls through the done cycle and reads the regfile next cycle.
- Outstanding count:
  - +1 on accepted issue (issue with RdE==0 still counts), -1 on LongDoneW, unchanged if both.
  - LongDoneW with count==0: count stays 0, SbError set; only reset clears it.
  - Count never exceeds MAX_OUT, because rule 3 blocks issue at full.
- SbBusy = |sb (combinational from registers).
- StallCnt: +1 per cycle with StallF=1 and CpuRst=0; saturates at all-ones.

Test Plan:
- Reset mid-operation: sb[5]=1, count=2, StallCnt=7; assert CpuRst between edges -> all regs 0 immediately, all Flush=1, Stall=0.
- Load-use: MemToRegE=1, RdE=3, Rs1D=3, RegReadD=10 -> StallF/D=1, FlushE=1 for one cycle; next cycle Forward1E=01 when RdW=3, Rs1E=3. Same with RdE=0 -> no stall.
- Scoreboard RAW: issue div to x7 (accepted), next cycle Rs2D=7, RegReadD=01 -> stall holds until the LongDoneW/LongRdW=7 cycle inclusive; released the cycle after; sb[7]=0, count=0.
- Full/WAW with MAX_OUT=4: four issues to x1..x4, fifth LongIssueE -> StallF/D/E=1, FlushM=1; one LongDoneW -> fifth accepted next cycle, count=4. Issue to x2 while sb[2]=1 -> same stall.
- Priority: DCacheMiss with BranchE -> only rule 1 outputs. ICacheMiss with RAW -> StallF/D=1, FlushE=1, FlushD=0. ICacheMiss alone -> StallF=1, FlushD=1.
- Forward priority and error: RdM=RdW=9=Rs1E, both writing -> Forward1E=10. LongDoneW at count 0 -> SbError=1 and sticky; StallCnt saturates at 2^PERF_W-1 (run with PERF_W=4: holds 15).
